// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 codes, FSM states,
// special-case constants and a small magnitude helper.
package muldiv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  localparam logic [XLEN-1:0] MD_ALL_ONES = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] MD_INT_MIN  = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } md_state_e;

  // Two's-complement magnitude; INT_MIN maps to itself, which is correct as unsigned.
  function automatic logic [XLEN-1:0] md_abs(input logic [XLEN-1:0] v, input logic neg);
    return neg ? ((~v) + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_addsub.sv
// 33-bit adder/subtractor shared by the multiply accumulate, the divide trial
// subtraction and the final sign correction.
module muldiv_addsub
  import muldiv_pkg::*;
(
  input  logic [XLEN:0] a,
  input  logic [XLEN:0] b,
  input  logic          invert_b,
  input  logic          cin,
  output logic [XLEN:0] sum,
  output logic          cout
);

  logic [XLEN:0]   b_eff;
  logic [XLEN+1:0] total;

  assign b_eff = invert_b ? ~b : b;
  assign total = {1'b0, a} + {1'b0, b_eff} + {{(XLEN+1){1'b0}}, cin};
  assign sum   = total[XLEN:0];
  assign cout  = total[XLEN+1];

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit (shift-add multiply, restoring divide).
// Define MULDIV_DIV_EN to build the divider; otherwise funct3 4-7 report illegal.
module ex_muldiv
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            illegal
);

  md_state_e       state_q, state_d;
  logic [2:0]      fn_q, fn_d;
  logic [XLEN-1:0] opnd_q, opnd_d;   // multiplicand or divisor
  logic [XLEN-1:0] lo_q, lo_d;       // multiplier/product low, or dividend/quotient
  logic [XLEN-1:0] hi_q, hi_d;       // product high, or partial remainder
  logic [4:0]      cnt_q, cnt_d;
  logic            prep_q, prep_d;
  logic            sa_q, sa_d;
  logic            sb_q, sb_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            illegal_q, illegal_d;
  logic [XLEN-1:0] result_q, result_d;

  logic [XLEN:0]   add_a, add_b, add_sum;
  logic            add_inv, add_cin, add_cout;
  logic            is_div_op;
  logic            signed_a, signed_b;
  logic            neg_res;
  logic [XLEN-1:0] fix_src;
  logic            fix_carry;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            unused_sum_msb;

`ifdef MULDIV_DIV_EN
  assign is_div_op = fn_q[2];
`else
  assign is_div_op = 1'b0;
`endif

  assign signed_a = (funct3 != MD_MULHU) && (funct3 != MD_DIVU) && (funct3 != MD_REMU);
  assign signed_b = signed_a && (funct3 != MD_MULHSU);

  assign mag_a = md_abs(opnd_q, sa_q);
  assign mag_b = md_abs(lo_q, sb_q);

  // Remainder follows the dividend's sign; everything else uses the XOR of signs.
  assign neg_res = (fn_q[2] && fn_q[1]) ? sa_q : (sa_q ^ sb_q);

  always_comb begin
    fix_src   = hi_q;
    fix_carry = 1'b1;
    if (fn_q[2]) begin
      fix_src = fn_q[1] ? hi_q : lo_q;
    end else if (fn_q == MD_MUL) begin
      fix_src = lo_q;
    end else begin
      // Negating the high word of a 64-bit value only carries in when the low word is zero.
      fix_src   = hi_q;
      fix_carry = (lo_q == '0);
    end
  end

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_inv = 1'b0;
    add_cin = 1'b0;
    if (state_q == ST_CALC && !prep_q) begin
      if (is_div_op) begin
        add_a   = {hi_q, lo_q[XLEN-1]};
        add_b   = {1'b0, opnd_q};
        add_inv = 1'b1;
        add_cin = 1'b1;
      end else begin
        add_a = {1'b0, hi_q};
        add_b = {1'b0, (lo_q[0] ? opnd_q : {XLEN{1'b0}})};
      end
    end else if (state_q == ST_FIX) begin
      add_b   = {1'b0, fix_src};
      add_inv = neg_res;
      add_cin = neg_res & fix_carry;
    end
  end

  muldiv_addsub u_addsub (
    .a        (add_a),
    .b        (add_b),
    .invert_b (add_inv),
    .cin      (add_cin),
    .sum      (add_sum),
    .cout     (add_cout)
  );

  assign unused_sum_msb = add_sum[XLEN] ^ add_cout;

  always_comb begin
    state_d   = state_q;
    fn_d      = fn_q;
    opnd_d    = opnd_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    cnt_d     = cnt_q;
    prep_d    = prep_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    illegal_d = 1'b0;
    result_d  = result_q;

    case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          fn_d   = funct3;
          opnd_d = op_a;
          lo_d   = op_b;
          hi_d   = '0;
          cnt_d  = '0;
          prep_d = 1'b1;
          sa_d   = signed_a & op_a[XLEN-1];
          sb_d   = signed_b & op_b[XLEN-1];
`ifdef MULDIV_DIV_EN
          if (funct3[2] && op_b == '0) begin
            state_d  = ST_DONE;
            result_d = funct3[1] ? op_a : MD_ALL_ONES;
          end else if ((funct3 == MD_DIV || funct3 == MD_REM) &&
                       op_a == MD_INT_MIN && op_b == MD_ALL_ONES) begin
            state_d  = ST_DONE;
            result_d = funct3[1] ? {XLEN{1'b0}} : MD_INT_MIN;
          end else begin
            state_d = ST_CALC;
          end
`else
          if (funct3[2]) begin
            state_d   = ST_DONE;
            result_d  = '0;
            illegal_d = 1'b1;
          end else begin
            state_d = ST_CALC;
          end
`endif
        end
      end

      ST_CALC: begin
        if (prep_q) begin
          // Raw operands were latched at start; magnitudes are formed here to keep
          // the sign conversion off the start path.
          prep_d = 1'b0;
          opnd_d = is_div_op ? mag_b : mag_a;
          lo_d   = is_div_op ? mag_a : mag_b;
        end else begin
          if (is_div_op) begin
            hi_d = add_cout ? add_sum[XLEN-1:0] : {hi_q[XLEN-2:0], lo_q[XLEN-1]};
            lo_d = {lo_q[XLEN-2:0], add_cout};
          end else begin
            hi_d = add_sum[XLEN:1];
            lo_d = {add_sum[0], lo_q[XLEN-1:1]};
          end
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d = ST_FIX;
          end
        end
      end

      ST_FIX: begin
        result_d = add_sum[XLEN-1:0];
        state_d  = ST_DONE;
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (flush) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      illegal_d = 1'b0;
      result_d  = result_q;
    end

    busy_d = (state_d == ST_CALC) || (state_d == ST_FIX);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      fn_q      <= '0;
      opnd_q    <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      cnt_q     <= '0;
      prep_q    <= 1'b0;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      fn_q      <= fn_d;
      opnd_q    <= opnd_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      cnt_q     <= cnt_d;
      prep_q    <= prep_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      result_q  <= result_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = result_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed-vector bench for ex_muldiv; divide vectors apply when MULDIV_DIV_EN is
// defined, otherwise divide opcodes are expected to report illegal.
module tb_ex_muldiv;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        flush = 1'b0;
  logic        busy, done, illegal;
  logic [31:0] result;

  int tests_run = 0;
  int errors = 0;

  ex_muldiv dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .funct3  (funct3),
    .op_a    (op_a),
    .op_b    (op_b),
    .flush   (flush),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .illegal (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Launches one operation and waits (bounded) for done; latency counts edges after
  // the edge that sampled start, busy counts cycles with busy high from that edge on.
  task automatic run_op(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int bcnt,
                        output logic ill);
    @(negedge clk);
    funct3 = fn;
    op_a   = a;
    op_b   = b;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat  = 0;
    bcnt = busy ? 1 : 0;
    while (!done && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy) bcnt++;
    end
    res = result;
    ill = illegal;
    $display("[TB] funct3=%0d a=%h b=%h -> result=%h latency=%0d busy_cycles=%0d illegal=%b",
             fn, a, b, res, lat, bcnt, ill);
    @(posedge clk);
  endtask

  logic [31:0] res;
  int          lat, bcnt, dcount;
  logic        ill;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_illegal", {31'd0, illegal}, 32'd0);
    check("reset_result", result, 32'h0000_0000);

    run_op(MD_MUL, 32'd7, 32'hFFFF_FFFD, res, lat, bcnt, ill);
    check("mul_7x-3", res, 32'hFFFF_FFEB);
    check("mul_latency", lat, 34);
    check("mul_busy_cycles", bcnt, 34);
    check("mul_illegal", {31'd0, ill}, 32'd0);

    run_op(MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat, bcnt, ill);
    check("mulhu_ff", res, 32'hFFFF_FFFE);
    run_op(MD_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat, bcnt, ill);
    check("mulh_ff", res, 32'h0000_0000);
    run_op(MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat, bcnt, ill);
    check("mulhsu_ff", res, 32'hFFFF_FFFF);
    run_op(MD_MUL, 32'd123456, 32'd1000, res, lat, bcnt, ill);
    check("mul_pos", res, 32'd123456000);

`ifdef MULDIV_DIV_EN
    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, res, lat, bcnt, ill);
    check("div_-7/2", res, 32'hFFFF_FFFD);
    check("div_latency", lat, 34);
    run_op(MD_REM, 32'hFFFF_FFF9, 32'd2, res, lat, bcnt, ill);
    check("rem_-7/2", res, 32'hFFFF_FFFF);
    run_op(MD_DIVU, 32'd100, 32'd7, res, lat, bcnt, ill);
    check("divu_100/7", res, 32'd14);
    run_op(MD_REMU, 32'd100, 32'd7, res, lat, bcnt, ill);
    check("remu_100/7", res, 32'd2);
    run_op(MD_DIVU, 32'd5, 32'd0, res, lat, bcnt, ill);
    check("divu_by0", res, 32'hFFFF_FFFF);
    check("divu_by0_latency", lat, 0);
    check("divu_by0_busy", bcnt, 0);
    run_op(MD_REMU, 32'd5, 32'd0, res, lat, bcnt, ill);
    check("remu_by0", res, 32'd5);
    check("remu_by0_latency", lat, 0);
    check("remu_by0_busy", bcnt, 0);
    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, bcnt, ill);
    check("div_ovf", res, 32'h8000_0000);
    check("div_ovf_latency", lat, 0);
    run_op(MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, bcnt, ill);
    check("rem_ovf", res, 32'h0000_0000);
`else
    run_op(MD_DIV, 32'd100, 32'd7, res, lat, bcnt, ill);
    check("div_illegal", {31'd0, ill}, 32'd1);
    check("div_illegal_result", res, 32'h0000_0000);
    check("div_illegal_latency", lat, 0);
    check("div_illegal_busy", bcnt, 0);
    #1;
    check("illegal_pulse_clears", {31'd0, illegal}, 32'd0);
    run_op(MD_REMU, 32'd5, 32'd3, res, lat, bcnt, ill);
    check("remu_illegal", {31'd0, ill}, 32'd1);
`endif

    // Establish a known result, then abort the next multiply.
    run_op(MD_MUL, 32'd6, 32'd7, res, lat, bcnt, ill);
    check("mul_6x7", res, 32'd42);

    @(negedge clk);
    funct3 = MD_MUL; op_a = 32'd3; op_b = 32'd5; start = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", {31'd0, busy}, 32'd0);
    check("flush_start_done", {31'd0, done}, 32'd0);
    $display("[TB] start+flush together: busy=%b done=%b", busy, done);

    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_done", {31'd0, done}, 32'd0);
    check("flush_result_held", result, 32'd42);
    dcount = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) dcount++;
    end
    check("flush_no_done", dcount, 0);
    $display("[TB] flush mid-multiply: busy=%b result=%h done_pulses=%0d", busy, result, dcount);

    run_op(MD_MUL, 32'd3, 32'd5, res, lat, bcnt, ill);
    check("after_flush_mul", res, 32'd15);
    check("after_flush_latency", lat, 34);

    @(negedge clk);
    funct3 = MD_MUL; op_a = 32'h0001_2345; op_b = 32'h10; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_illegal", {31'd0, illegal}, 32'd0);
    check("rst_result", result, 32'h0000_0000);
    $display("[TB] reset mid-multiply: busy=%b done=%b result=%h", busy, done, result);

    run_op(MD_MUL, 32'h0001_2345, 32'h10, res, lat, bcnt, ill);
    check("after_rst_mul", res, 32'h0012_3450);

    $display("[TB] %0d tests run, %0d failed", tests_run, errors);
    $finish;
  end

endmodule
